// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 controller: command bytes, FSM and
// write-phase encodings, and the power-on command table.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_INIT,
        ST_WAIT,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2
    } state_e;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_e;

    // Init command issued at each step of the power-on sequence; clear is last.
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Three-tick LCD byte strobe: SETUP latches rs/data, PULSE raises E,
// HOLD drops E with the bus held; the next byte may start on the following tick.
module lcd_byte_writer
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_clk_i,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o
);

    phase_e     phase_q, phase_d;
    logic       e_q, e_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;

    // Phase and bus registers, advanced only on pacing ticks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= PH_SETUP;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // Phase sequencing; rs/data are sampled only on the SETUP tick.
    always_comb begin
        phase_d = phase_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        if (en_clk_i) begin
            case (phase_q)
                PH_SETUP: begin
                    if (start_i) begin
                        rs_d    = rs_i;
                        data_d  = data_i;
                        e_d     = 1'b0;
                        phase_d = PH_PULSE;
                    end else begin
                        phase_d = PH_SETUP;
                    end
                end
                PH_PULSE: begin
                    e_d     = 1'b1;
                    phase_d = PH_HOLD;
                end
                PH_HOLD: begin
                    e_d     = 1'b0;
                    phase_d = PH_SETUP;
                end
                default: begin
                    e_d     = 1'b0;
                    phase_d = PH_SETUP;
                end
            endcase
        end else begin
            phase_d = phase_q;
        end
    end

    assign done_o     = en_clk_i && (phase_q == PH_HOLD);
    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 write-only controller: power-on init, then endless two-line refresh.
// Optional frame_done output is enabled by defining LCD_FRAME_DONE_EN.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int PWR_WAIT = 20,
    parameter int CLR_WAIT = 2,
    parameter int LINE_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_clk,
    input  logic [7:0] data_char,
    output logic [4:0] index_char,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
`ifdef LCD_FRAME_DONE_EN
    ,
    output logic       frame_done
`endif
);

    localparam int WAIT_MAX = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int STEP_W   = $clog2(LINE_LEN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [4:0]        index_q, index_d;

    logic       wr_done_s;
    logic       start_s;
    logic       rs_s;
    logic [7:0] byte_s;

    lcd_byte_writer u_writer (
        .clk        (clk),
        .rst        (rst),
        .en_clk_i   (en_clk),
        .start_i    (start_s),
        .rs_i       (rs_s),
        .data_i     (byte_s),
        .done_o     (wr_done_s),
        .lcd_e_o    (lcd_e),
        .lcd_rs_o   (lcd_rs),
        .lcd_data_o (lcd_data)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_PWR;
            cnt_q   <= '0;
            step_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            index_q <= index_d;
        end
    end

    // Next-state logic; index_char moves only on HOLD ticks so upstream data settles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        index_d = index_q;
        if (en_clk) begin
            case (state_q)
                ST_PWR: begin
                    if (cnt_q == CNT_W'(PWR_WAIT - 1)) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_INIT: begin
                    if (wr_done_s) begin
                        if (step_q == STEP_W'(3)) begin
                            state_d = ST_WAIT;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end else begin
                        step_d = step_q;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_W'(CLR_WAIT - 1)) begin
                        state_d = ST_ADDR1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ADDR1, ST_ADDR2: begin
                    if (wr_done_s) begin
                        state_d = (state_q == ST_ADDR1) ? ST_LINE1 : ST_LINE2;
                        step_d  = '0;
                        index_d = (state_q == ST_ADDR1) ? 5'd0 : 5'(LINE_LEN);
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LINE1, ST_LINE2: begin
                    if (wr_done_s) begin
                        if (step_q == STEP_W'(LINE_LEN - 1)) begin
                            // Line 1 keeps its last index until the C0 hold; line 2 wraps to 0.
                            state_d = (state_q == ST_LINE1) ? ST_ADDR2 : ST_ADDR1;
                            step_d  = '0;
                            index_d = (state_q == ST_LINE1) ? index_q : 5'd0;
                        end else begin
                            step_d  = step_q + STEP_W'(1);
                            index_d = index_q + 5'd1;
                        end
                    end else begin
                        step_d = step_q;
                    end
                end
                default: begin
                    state_d = ST_PWR;
                    cnt_d   = '0;
                    step_d  = '0;
                    index_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Byte source for the writer in each state.
    always_comb begin
        start_s = 1'b0;
        rs_s    = 1'b0;
        byte_s  = 8'h00;
        case (state_q)
            ST_INIT: begin
                start_s = 1'b1;
                byte_s  = init_cmd(step_q[1:0]);
            end
            ST_ADDR1: begin
                start_s = 1'b1;
                byte_s  = LCD_LINE1;
            end
            ST_ADDR2: begin
                start_s = 1'b1;
                byte_s  = LCD_LINE2;
            end
            ST_LINE1, ST_LINE2: begin
                start_s = 1'b1;
                rs_s    = 1'b1;
                byte_s  = data_char;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    assign index_char = index_q;
    assign lcd_rw     = 1'b0;

`ifdef LCD_FRAME_DONE_EN
    logic frame_done_q;
    logic last_char_done_s;

    assign last_char_done_s = wr_done_s && (state_q == ST_LINE2)
                              && (step_q == STEP_W'(LINE_LEN - 1));

    // One-clk pulse when the final LINE2 hold completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_char_done_s;
        end
    end

    assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Randomized bench for lcd_hd44780_ctrl against a tick-count reference model.
module tb_lcd_hd44780_ctrl;

    localparam int PWR_WAIT = 20;
    localparam int CLR_WAIT = 2;
    localparam int LINE_LEN = 16;
    localparam int INIT_END = PWR_WAIT + 12;
    localparam int REF_BASE = PWR_WAIT + 12 + CLR_WAIT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_clk = 1'b0;
    logic [7:0] data_char = 8'h00;
    logic [4:0] index_char;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
`ifdef LCD_FRAME_DONE_EN
    logic       frame_done;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int tick = 0;
    bit last_en = 1'b0;
    logic [7:0] str_mem [32];
    logic [7:0] init_tab [4];

    lcd_hd44780_ctrl #(
        .PWR_WAIT (PWR_WAIT),
        .CLR_WAIT (CLR_WAIT),
        .LINE_LEN (LINE_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_clk     (en_clk),
        .data_char  (data_char),
        .index_char (index_char),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data)
`ifdef LCD_FRAME_DONE_EN
        ,
        .frame_done (frame_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (tick %0d, t=%0t)", tag, obs, exp, tick, $time);
        end
    endtask

    // Which byte (b) and phase (0 setup, 1 pulse, 2 hold) tick t belongs to.
    function automatic void classify(input int t, output int b, output int ph, output bit in_byte);
        in_byte = 1'b0;
        b = 0;
        ph = 0;
        if (t > PWR_WAIT && t <= INIT_END) begin
            in_byte = 1'b1;
            b  = (t - PWR_WAIT - 1) / 3;
            ph = (t - PWR_WAIT - 1) % 3;
        end else if (t > REF_BASE) begin
            in_byte = 1'b1;
            b  = 4 + (t - REF_BASE - 1) / 3;
            ph = (t - REF_BASE - 1) % 3;
        end
    endfunction

    function automatic void exp_byte(input int b, output logic rs, output logic [7:0] d);
        int r;
        if (b < 4) begin
            rs = 1'b0;
            d  = init_tab[b];
        end else begin
            r = (b - 4) % 34;
            if (r == 0) begin
                rs = 1'b0; d = 8'h80;
            end else if (r == 17) begin
                rs = 1'b0; d = 8'hC0;
            end else if (r < 17) begin
                rs = 1'b1; d = str_mem[r - 1];
            end else begin
                rs = 1'b1; d = str_mem[16 + r - 18];
            end
        end
    endfunction

    function automatic int exp_index(input int t);
        int b, ph, r, c;
        bit ib;
        classify(t, b, ph, ib);
        if (!ib || b < 4) return 0;
        r = (b - 4) % 34;
        if (r == 0) return 0;
        if (r == 17) return (ph == 2) ? 16 : 15;
        if (r < 17) begin
            c = r - 1;
            return (ph == 2 && c < 15) ? c + 1 : c;
        end
        c = r - 18;
        if (ph == 2) return (c < 15) ? 17 + c : 0;
        return 16 + c;
    endfunction

    function automatic bit is_setup(input int t);
        int b, ph;
        bit ib;
        classify(t, b, ph, ib);
        return ib && (ph == 0);
    endfunction

    task automatic check_outputs();
        int b, ph;
        bit ib;
        logic rs_e;
        logic [7:0] d_e;
        classify(tick, b, ph, ib);
        check_eq("rw", 32'(lcd_rw), 32'd0);
        check_eq("index", 32'(index_char), 32'(exp_index(tick)));
        if (ib) begin
            exp_byte(b, rs_e, d_e);
            check_eq("e", 32'(lcd_e), 32'(ph == 1));
            check_eq("rs", 32'(lcd_rs), 32'(rs_e));
            check_eq("data", 32'(lcd_data), 32'(d_e));
        end else begin
            check_eq("e_idle", 32'(lcd_e), 32'd0);
            check_eq("rs_idle", 32'(lcd_rs), 32'd0);
            check_eq("data_idle", 32'(lcd_data), (tick <= PWR_WAIT) ? 32'h00 : 32'h01);
        end
`ifdef LCD_FRAME_DONE_EN
        check_eq("frame_done", 32'(frame_done),
                 32'(last_en && ib && b >= 4 && ((b - 4) % 34) == 33 && ph == 2));
`endif
    endtask

    // One clk cycle: present inputs, advance the model, check after the edge.
    task automatic step(input logic en);
        en_clk = en;
        if (en && rst && is_setup(tick + 1)) data_char = str_mem[index_char];
        else data_char = 8'($urandom);
        @(posedge clk);
        if (!rst) tick = 0;
        else if (en) tick = tick + 1;
        last_en = en && rst;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        init_tab[0] = 8'h38;
        init_tab[1] = 8'h0C;
        init_tab[2] = 8'h06;
        init_tab[3] = 8'h01;
        for (int i = 0; i < 32; i++) str_mem[i] = 8'($urandom_range(32, 126));

        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)));
        rst = 1'b1;

        for (int i = 0; i < 600; i++) step(i % 4 == 3);
        for (int i = 0; i < 200; i++) step(1'b0);
        for (int i = 0; i < 800; i++) step($urandom_range(0, 2) == 0);
        for (int i = 0; i < 20; i++) step(1'b1);

        for (int i = 0; i < 64 && !lcd_e; i++) step(1'b1);
        check_eq("pulse_seen", 32'(lcd_e), 32'd1);
        rst = 1'b0;
        step(1'b1);
        rst = 1'b1;

        for (int i = 0; i < 300; i++) step(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
